// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot controller and its upstream stages.
package parking_pkg;

  localparam int MAX_CAP       = 700;
  localparam int HOURS_PER_DAY = 24;

  typedef logic [4:0] hour_t;

  typedef enum logic {
    SEQ_SYNC,
    SEQ_RUN
  } seq_state_t;

endpackage

// File: rtl/gate_event_fifo.sv
// One-bit event queue for one side of the lot; the stored bit means "university car".
// Simultaneous requests enqueue uni before pub, and a same-cycle pop frees a slot first.
module gate_event_fifo #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_uni,
  input  logic          push_pub,
  input  logic          pop,
  output logic          head,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr, wr_ptr, pub_ptr, wr_next;
  logic [CW-1:0]    base, after_uni;
  logic             do_pop, acc_uni, acc_pub;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop & ~empty;

  always_comb begin
    base      = count - CW'(do_pop);
    acc_uni   = push_uni && (base < CW'(DEPTH));
    after_uni = base + CW'(acc_uni);
    acc_pub   = push_pub && (after_uni < CW'(DEPTH));
    pub_ptr   = acc_uni ? ptr_inc(wr_ptr) : wr_ptr;
    wr_next   = acc_pub ? ptr_inc(pub_ptr) : pub_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc_uni) mem[wr_ptr] <= 1'b1;
      if (acc_pub) mem[pub_ptr] <= 1'b0;
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      wr_ptr   <= wr_next;
      count    <= after_uni + CW'(acc_pub);
      overflow <= overflow | (push_uni & ~acc_uni) | (push_pub & ~acc_pub);
    end
  end

endmodule

// File: rtl/parking_gate_sequencer.sv
// Queues gate events and hands at most one entry and one exit to the lot per update pass,
// changing its event outputs only right after the rising edge of the lot's ready signal.
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int    DEPTH          = 4,
  parameter int    TICKS_PER_HOUR = 60,
  parameter hour_t START_HOUR     = 5'd8,
  localparam int   CW             = $clog2(DEPTH + 1),
  localparam int   TW             = $clog2(TICKS_PER_HOUR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uni_entry_req,
  input  logic          pub_entry_req,
  input  logic          uni_exit_req,
  input  logic          pub_exit_req,
  input  logic          lot_ready,
  output logic          car_entered,
  output logic          is_uni_car_entered,
  output logic          car_exited,
  output logic          is_uni_car_exited,
  output hour_t         in_out_time,
  output logic [CW-1:0] entry_count,
  output logic [CW-1:0] exit_count,
  output logic          entry_overflow,
  output logic          exit_overflow
);

  seq_state_t    state;
  logic          lot_ready_q, pass_done;
  logic          entry_head, entry_empty, exit_head, exit_empty;
  logic [TW-1:0] tick;

  assign pass_done = lot_ready & ~lot_ready_q;

  gate_event_fifo #(.DEPTH(DEPTH)) u_entry_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_uni (uni_entry_req),
    .push_pub (pub_entry_req),
    .pop      (pass_done),
    .head     (entry_head),
    .empty    (entry_empty),
    .count    (entry_count),
    .overflow (entry_overflow)
  );

  gate_event_fifo #(.DEPTH(DEPTH)) u_exit_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_uni (uni_exit_req),
    .push_pub (pub_exit_req),
    .pop      (pass_done),
    .head     (exit_head),
    .empty    (exit_empty),
    .count    (exit_count),
    .overflow (exit_overflow)
  );

  // The init pass in SYNC has nothing to retire, so both states load the queue heads alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= SEQ_SYNC;
      lot_ready_q        <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      lot_ready_q <= lot_ready;
      if (pass_done) begin
        case (state)
          SEQ_SYNC: state <= SEQ_RUN;
          SEQ_RUN:  state <= SEQ_RUN;
          default:  state <= SEQ_SYNC;
        endcase
        car_entered        <= ~entry_empty;
        is_uni_car_entered <= ~entry_empty & entry_head;
        car_exited         <= ~exit_empty;
        is_uni_car_exited  <= ~exit_empty & exit_head;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick        <= '0;
      in_out_time <= START_HOUR;
    end else if (tick == TW'(TICKS_PER_HOUR - 1)) begin
      tick        <= '0;
      in_out_time <= (in_out_time == hour_t'(HOURS_PER_DAY - 1)) ? '0 : in_out_time + 5'd1;
    end else begin
      tick <= tick + TW'(1);
    end
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Randomized bench for parking_gate_sequencer against a queue-based reference model.
module tb_parking_gate_sequencer;

  localparam int DEPTH = 4;
  localparam int TPH   = 2;
  localparam int START = 23;

  logic       clk = 1'b0;
  logic       rst;
  logic       uni_entry_req, pub_entry_req, uni_exit_req, pub_exit_req, lot_ready;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic [4:0] in_out_time;
  logic [2:0] entry_count, exit_count;
  logic       entry_overflow, exit_overflow;

  int n_vectors = 0;
  int n_miscompares = 0;

  // reference model state
  bit m_entry_q[$];
  bit m_exit_q[$];
  bit m_car_in, m_uni_in, m_car_out, m_uni_out;
  bit m_ovf_in, m_ovf_out, m_lr_prev;
  int m_tick, m_hour;

  parking_gate_sequencer #(
    .DEPTH          (DEPTH),
    .TICKS_PER_HOUR (TPH),
    .START_HOUR     (5'(START))
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .uni_entry_req      (uni_entry_req),
    .pub_entry_req      (pub_entry_req),
    .uni_exit_req       (uni_exit_req),
    .pub_exit_req       (pub_exit_req),
    .lot_ready          (lot_ready),
    .car_entered        (car_entered),
    .is_uni_car_entered (is_uni_car_entered),
    .car_exited         (car_exited),
    .is_uni_car_exited  (is_uni_car_exited),
    .in_out_time        (in_out_time),
    .entry_count        (entry_count),
    .exit_count         (exit_count),
    .entry_overflow     (entry_overflow),
    .exit_overflow      (exit_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("car_entered", int'(car_entered), int'(m_car_in));
    checkOutput("is_uni_car_entered", int'(is_uni_car_entered), int'(m_uni_in));
    checkOutput("car_exited", int'(car_exited), int'(m_car_out));
    checkOutput("is_uni_car_exited", int'(is_uni_car_exited), int'(m_uni_out));
    checkOutput("entry_count", int'(entry_count), m_entry_q.size());
    checkOutput("exit_count", int'(exit_count), m_exit_q.size());
    checkOutput("entry_overflow", int'(entry_overflow), int'(m_ovf_in));
    checkOutput("exit_overflow", int'(exit_overflow), int'(m_ovf_out));
    checkOutput("in_out_time", int'(in_out_time), m_hour);
  endtask

  function automatic void modelReset();
    m_entry_q.delete();
    m_exit_q.delete();
    m_car_in = 0; m_uni_in = 0; m_car_out = 0; m_uni_out = 0;
    m_ovf_in = 0; m_ovf_out = 0; m_lr_prev = 0;
    m_tick = 0; m_hour = START;
  endfunction

  // One clock edge of the intended behaviour: serve the pass, then accept arrivals.
  function automatic void modelStep(input bit ue, input bit pe, input bit ux, input bit px, input bit lr);
    bit pass;
    pass = lr && !m_lr_prev;
    m_lr_prev = lr;
    if (pass) begin
      m_car_in  = (m_entry_q.size() > 0);
      m_uni_in  = m_car_in ? m_entry_q.pop_front() : 1'b0;
      m_car_out = (m_exit_q.size() > 0);
      m_uni_out = m_car_out ? m_exit_q.pop_front() : 1'b0;
    end
    if (ue) begin if (m_entry_q.size() < DEPTH) m_entry_q.push_back(1'b1); else m_ovf_in = 1; end
    if (pe) begin if (m_entry_q.size() < DEPTH) m_entry_q.push_back(1'b0); else m_ovf_in = 1; end
    if (ux) begin if (m_exit_q.size() < DEPTH) m_exit_q.push_back(1'b1); else m_ovf_out = 1; end
    if (px) begin if (m_exit_q.size() < DEPTH) m_exit_q.push_back(1'b0); else m_ovf_out = 1; end
    m_tick++;
    if (m_tick == TPH) begin
      m_tick = 0;
      m_hour = (m_hour + 1) % 24;
    end
  endfunction

  // Called at a falling edge; drives one cycle of inputs and checks after the next rising edge.
  task automatic applyStimulus(input bit ue, input bit pe, input bit ux, input bit px, input bit lr);
    uni_entry_req = ue;
    pub_entry_req = pe;
    uni_exit_req  = ux;
    pub_exit_req  = px;
    lot_ready     = lr;
    modelStep(ue, pe, ux, px, lr);
    @(negedge clk);
    checkAll();
  endtask

  task automatic midReset();
    uni_entry_req = 0; pub_entry_req = 0; uni_exit_req = 0; pub_exit_req = 0; lot_ready = 0;
    #2 rst = 1'b1;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    checkAll();
    rst = 1'b0;
  endtask

  task automatic pass();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    uni_entry_req = 0; pub_entry_req = 0; uni_exit_req = 0; pub_exit_req = 0; lot_ready = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;

    // Entry queued before the init pass.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Entry and exit in one cycle, then a pass, then an empty pass.
    applyStimulus(1, 0, 0, 1, 0);
    pass();
    pass();

    // Overfill the entry queue and drain it.
    repeat (5) applyStimulus(0, 1, 0, 0, 0);
    repeat (5) pass();

    // Full queue with both requests arriving on the pass edge.
    repeat (4) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Ready held high for several cycles gives a single pop.
    repeat (5) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Asynchronous reset with events queued and presented.
    applyStimulus(1, 1, 1, 1, 0);
    pass();
    applyStimulus(0, 1, 1, 0, 0);
    midReset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) midReset();
      else applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
